// File: rtl/cache_refill_engine_pkg.sv
// Shared constants, refill FSM states and miss-address field helpers.
// Used by the refill engine and its line assembly buffer.
package cache_refill_engine_pkg;

  localparam int TAG_W  = 24;
  localparam int IDX_W  = 3;
  localparam int OFF_W  = 5;
  localparam int WORD_W = 32;
  localparam int BEATS  = 8;
  localparam int LINE_W = 256;
  localparam int WSEL_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(
    input logic [31:0] a
  );
    return a[31:32-TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(
    input logic [31:0] a
  );
    return a[OFF_W+IDX_W-1:OFF_W];
  endfunction

  function automatic logic [WSEL_W-1:0] addr_wsel(
    input logic [31:0] a
  );
    return a[OFF_W-1:2];
  endfunction

endpackage

// File: rtl/refill_line_buffer.sv
// Beat counter and 8x32 line assembly register with critical-word mux.
// Ports: clk/rst, beat_we_i/beat_data_i in, wsel_i in, full_o/line_o/word_o out.
module refill_line_buffer
  import cache_refill_engine_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_we_i,
  input  logic [WORD_W-1:0] beat_data_i,
  input  logic [WSEL_W-1:0] wsel_i,
  output logic              full_o,
  output logic [LINE_W-1:0] line_o,
  output logic [WORD_W-1:0] word_o
);

  logic [2:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] mem_q [BEATS];

  // Counter wraps 7->0 on the last beat, ready for the next refill.
  always_comb begin
    cnt_d = cnt_q;
    if (beat_we_i) cnt_d = cnt_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 3'd0;
    else      cnt_q <= cnt_d;
  end

  // Data storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (beat_we_i) mem_q[cnt_q] <= beat_data_i;
  end

  always_comb begin
    line_o = '0;
    for (int i = 0; i < BEATS; i++)
      line_o[i*WORD_W +: WORD_W] = mem_q[i];
  end

  assign full_o = (cnt_q == 3'd7);
  assign word_o = mem_q[wsel_i];

endmodule

// File: rtl/cache_refill_engine.sv
// Cache miss refill engine: one burst read, line assembly, array write.
// Ports: miss_* from lookup, mem_req_*/mem_rsp_* to memory, tag_*/data_* arrays, refill_* result.
module cache_refill_engine
  import cache_refill_engine_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [31:0]       miss_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       mem_req_addr,
  output logic [7:0]        mem_req_len,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [WORD_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_last,
  output logic              tag_wen,
  output logic [IDX_W-1:0]  tag_waddr,
  output logic [TAG_W-1:0]  tag_wdata,
  output logic              data_wen,
  output logic [IDX_W-1:0]  data_waddr,
  output logic [LINE_W-1:0] data_wdata,
  output logic              refill_done,
  output logic [WORD_W-1:0] refill_word,
  output logic              refill_err,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WSEL_W-1:0] wsel_q, wsel_d;
  logic              err_q, err_d;

  logic              beat_we;
  logic              full;
  logic [LINE_W-1:0] line;
  logic [WORD_W-1:0] crit;

  refill_line_buffer u_buf (
    .clk         (clk),
    .rst         (rst),
    .beat_we_i   (beat_we),
    .beat_data_i (mem_rsp_data),
    .wsel_i      (wsel_q),
    .full_o      (full),
    .line_o      (line),
    .word_o      (crit)
  );

  assign mem_req_len = 8'(BEATS - 1);
  assign busy        = (state_q != S_IDLE);

  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    idx_d         = idx_q;
    wsel_d        = wsel_q;
    err_d         = err_q;
    beat_we       = 1'b0;
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_rsp_ready = 1'b0;
    tag_wen       = 1'b0;
    tag_waddr     = '0;
    tag_wdata     = '0;
    data_wen      = 1'b0;
    data_waddr    = '0;
    data_wdata    = '0;
    refill_done   = 1'b0;
    refill_word   = '0;
    refill_err    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          tag_d   = addr_tag(miss_addr);
          idx_d   = addr_idx(miss_addr);
          wsel_d  = addr_wsel(miss_addr);
          err_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag_q, idx_q, {OFF_W{1'b0}}};
        if (mem_req_ready) state_d = S_RECV;
      end
      S_RECV: begin
        mem_rsp_ready = 1'b1;
        beat_we       = mem_rsp_valid;
        if (mem_rsp_valid) begin
          // last must coincide exactly with the eighth beat
          if (mem_rsp_last != full) err_d = 1'b1;
          if (full) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        tag_wen    = 1'b1;
        tag_waddr  = idx_q;
        tag_wdata  = tag_q;
        data_wen   = 1'b1;
        data_waddr = idx_q;
        data_wdata = line;
        state_d    = S_DONE;
      end
      S_DONE: begin
        refill_done = 1'b1;
        refill_word = crit;
        refill_err  = err_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      wsel_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      wsel_q  <= wsel_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cache_refill_engine.sv
// Scoreboard bench for cache_refill_engine: directed plan plus random refills.
// Driver acts as lookup stage and memory; monitor checks array writes and done.
`timescale 1ns/1ps
module tb_cache_refill_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         miss_valid = 1'b0;
  logic         miss_ready;
  logic [31:0]  miss_addr = '0;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic [31:0]  mem_req_addr;
  logic [7:0]   mem_req_len;
  logic         mem_rsp_valid = 1'b0;
  logic         mem_rsp_ready;
  logic [31:0]  mem_rsp_data = '0;
  logic         mem_rsp_last = 1'b0;
  logic         tag_wen;
  logic [2:0]   tag_waddr;
  logic [23:0]  tag_wdata;
  logic         data_wen;
  logic [2:0]   data_waddr;
  logic [255:0] data_wdata;
  logic         refill_done;
  logic [31:0]  refill_word;
  logic         refill_err;
  logic         busy;

  always #5 clk = ~clk;

  cache_refill_engine dut (
    .clk           (clk),
    .rst           (rst),
    .miss_valid    (miss_valid),
    .miss_ready    (miss_ready),
    .miss_addr     (miss_addr),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_len   (mem_req_len),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_last  (mem_rsp_last),
    .tag_wen       (tag_wen),
    .tag_waddr     (tag_waddr),
    .tag_wdata     (tag_wdata),
    .data_wen      (data_wen),
    .data_waddr    (data_waddr),
    .data_wdata    (data_wdata),
    .refill_done   (refill_done),
    .refill_word   (refill_word),
    .refill_err    (refill_err),
    .busy          (busy)
  );

  typedef struct {
    logic [23:0]  tag;
    logic [2:0]   idx;
    logic [255:0] line;
    int           base;
    int           k;
  } wr_t;

  typedef struct {
    logic [31:0] word;
    logic        err;
    int          base;
    int          k;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_hs = 0;
  int wr_cnt = 0;
  int last_done_cyc = -100;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req_valid && mem_req_ready) req_hs <= req_hs + 1;
    if (tag_wen || data_wen) wr_cnt <= wr_cnt + 1;
  end

  // Monitor: pops expected results whenever the DUT presents them.
  always @(negedge clk) begin
    wr_t e;
    dn_t d;
    if (tag_wen || data_wen) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = wq.pop_front();
        chk("wen_pair", {tag_wen, data_wen}, 2'b11);
        chk("tag_waddr", tag_waddr, e.idx);
        chk("data_waddr", data_waddr, e.idx);
        chk("tag_wdata", tag_wdata, e.tag);
        chk("data_wdata", data_wdata, e.line);
        if (e.k >= 0) chk("write_cycle", cyc - e.base, e.k);
      end
    end
    if (refill_done) begin
      if (dq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        d = dq.pop_front();
        chk("refill_word", refill_word, d.word);
        chk("refill_err", refill_err, d.err);
        if (d.k >= 0) chk("done_cycle", cyc - d.base, d.k);
      end
      last_done_cyc = cyc;
    end
  end

  task automatic reset_check(input string nm);
    chk({nm, "_miss_ready"}, miss_ready, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_req_len"}, mem_req_len, 7);
    chk({nm, "_ctl"}, {mem_req_valid, mem_rsp_ready, tag_wen,
                       data_wen, refill_done, refill_err}, 0);
    chk({nm, "_buses"}, {mem_req_addr, refill_word, tag_waddr,
                         tag_wdata, data_waddr}, 0);
    chk({nm, "_wdata"}, data_wdata, 0);
  endtask

  // Caller is at a negedge. gap: 0 none, 1 alternating, 2 random.
  task automatic run_miss(input logic [31:0] addr, input int req_wait,
                          input int gap, input logic [7:0] lastpat,
                          input int abort_at, input bit hold,
                          input logic [31:0] next_addr,
                          input bit chk_b2b, input bit seqd);
    logic [31:0]  beats[8];
    logic [255:0] line;
    logic         err;
    int base, hs0, wr0, k, w, n, bound, kw;
    bit mr_bad, drive;
    for (int i = 0; i < 8; i++) begin
      beats[i] = seqd ? 32'hA0 + i : $urandom;
      line[32*i +: 32] = beats[i];
    end
    err = (lastpat != 8'h80);
    kw  = (gap == 0) ? 10 + req_wait : -1;
    miss_valid = 1'b1;
    miss_addr  = addr;
    bound = 0;
    while (!miss_ready) begin
      @(negedge clk);
      if (++bound > 40) begin
        chk("miss_accept_timeout", 0, 1);
        miss_valid = 1'b0;
        return;
      end
    end
    base = cyc;
    if (chk_b2b) chk("b2b_accept_cycle", base, last_done_cyc + 1);
    if (abort_at < 0) begin
      wq.push_back('{addr[31:8], addr[7:5], line, base, kw});
      dq.push_back('{beats[addr[4:2]], err, base,
                     (kw >= 0) ? kw + 1 : -1});
    end
    hs0 = req_hs;
    wr0 = wr_cnt;
    mr_bad = 1'b0;
    @(negedge clk);
    if (hold) miss_addr = next_addr;
    else miss_valid = 1'b0;
    w = 0;
    while (1) begin
      if (miss_ready) mr_bad = 1'b1;
      chk("req_valid", mem_req_valid, 1);
      chk("req_addr", mem_req_addr, {addr[31:5], 5'b0});
      if (w == req_wait) begin
        mem_req_ready = 1'b1;
        break;
      end
      w++;
      @(negedge clk);
    end
    @(negedge clk);
    mem_req_ready = 1'b0;
    k = 0;
    n = 0;
    while (k < 8) begin
      if (miss_ready) mr_bad = 1'b1;
      if (abort_at >= 0 && k == abort_at) break;
      drive = (gap == 0) || (gap == 1 && n % 2 == 0) ||
              (gap == 2 && $urandom_range(1, 0) == 1);
      if (drive) begin
        chk("rsp_ready", mem_rsp_ready, 1);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = beats[k];
        mem_rsp_last  = lastpat[k];
        k++;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
        mem_rsp_last  = $urandom_range(1, 0) == 1;
      end
      n++;
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_last  = 1'b0;
    if (abort_at >= 0) begin
      rst = 1'b0;
      #1;
      reset_check("rst_mid_recv");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      chk("abort_no_write", wr_cnt - wr0, 0);
      return;
    end
    bound = 0;
    while (1) begin
      if (miss_ready) mr_bad = 1'b1;
      if (refill_done) break;
      if (++bound > 40) begin
        chk("done_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    chk("miss_ready_low_in_refill", mr_bad, 0);
    chk("req_handshakes", req_hs - hs0, 1);
    chk("array_writes", wr_cnt - wr0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a1, a2;
    logic [7:0]  lp;
    #12;
    reset_check("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_miss(32'h1234_56E8, 0, 0, 8'h80, -1, 0, 0, 0, 1);
    run_miss($urandom, 5, 0, 8'h80, -1, 0, 0, 0, 0);
    run_miss($urandom, 0, 1, 8'h80, -1, 0, 0, 0, 0);
    run_miss($urandom, 0, 0, 8'h08, -1, 0, 0, 0, 0);
    run_miss($urandom, 1, 0, 8'h80, 4, 0, 0, 0, 0);
    @(negedge clk);
    run_miss($urandom, 0, 0, 8'h80, -1, 0, 0, 0, 0);
    a1 = $urandom;
    a2 = $urandom;
    run_miss(a1, 0, 0, 8'h80, -1, 1, a2, 0, 0);
    run_miss(a2, 0, 0, 8'h80, -1, 0, 0, 1, 0);
    for (int i = 0; i < 24; i++) begin
      lp = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h80;
      run_miss($urandom, $urandom_range(3, 0), $urandom_range(2, 0),
               lp, -1, 0, 0, 0, 0);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("write_queue_drained", wq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_refill_engine.md
Name: cache_refill_engine

Overview:
- Miss-handling writer for the cache tag array and data array.
- Accepts a miss address from the lookup stage and issues one line-aligned burst read to memory.
- Assembles eight 32-bit response beats into a 256-bit line, then writes tag, valid and data into the arrays in a single cycle.
- Returns the critical word to the lookup stage with a one-cycle done pulse.

Parameters:
- TAG_W, 24, tag width; matches the tag array data width.
- IDX_W, 3, set index width; matches the tag array address width (8 sets).
- OFF_W, 5, byte offset width (32-byte line).
- WORD_W, 32, memory beat width.
- BEATS, 8, beats per line (2^OFF_W*8/WORD_W).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- miss_valid  in  1  miss request valid
- miss_ready  out  1  engine can accept a miss
- miss_addr  in  32  miss byte address
- mem_req_valid  out  1  burst read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  line-aligned address; low OFF_W bits are 0
- mem_req_len  out  8  constant BEATS-1 (7)
- mem_rsp_valid  in  1  response beat valid
- mem_rsp_ready  out  1  engine accepts beat
- mem_rsp_data  in  32  beat data
- mem_rsp_last  in  1  final beat marker
- tag_wen  out  1  tag array write enable; also sets the valid bit
- tag_waddr  out  3  set index
- tag_wdata  out  24  tag
- data_wen  out  1  data array write enable
- data_waddr  out  3  set index
- data_wdata  out  256  line; beat k occupies bits [32k+31:32k]
- refill_done  out  1  one-cycle completion pulse
- refill_word  out  32  critical word (word at miss_addr[4:2]); valid only with refill_done
- refill_err  out  1  valid with refill_done; last-marker mismatch seen
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst==0, asynchronous): state=IDLE; beat counter=0; error flag=0; every output 0 except miss_ready=1 and mem_req_len=7. Line buffer is not reset; its contents are don't-care.
- States: IDLE, REQ, RECV, WRITE, DONE. Encoding is one-hot or binary, implementer's choice.
- IDLE: miss_ready=1. If miss_valid, latch addr[31:8] as tag, addr[7:5] as index, addr[4:2] as word select, clear the error flag, then go to REQ.
- REQ: mem_req_valid=1 and mem_req_addr={tag,idx,5'b0}, both held stable until mem_req_ready. Go to RECV on the handshake.
- RECV: mem_rsp_ready=1. Each mem_rsp_valid&&mem_rsp_ready beat writes buffer word[cnt] and increments cnt. Gaps in valid are allowed.
  - On the beat with cnt==7: go to WRITE and reset cnt to 0.
  - Error flag is set if mem_rsp_last==1 with cnt<7, or mem_rsp_last==0 with cnt==7.
  - An early last does not end the burst; the engine always consumes exactly 8 beats.
- WRITE: tag_wen=data_wen=1 for exactly one cycle. Addresses come from the latched index, tag_wdata is the latched tag, data_wdata is the buffer. Then go to DONE.
- DONE: refill_done=1, refill_word=buffer[word select], refill_err=error flag, all for one cycle. Then go to IDLE.
- Handshake rules:
  - miss_ready is 0 in all states except IDLE, so a miss presented during DONE is accepted on the following cycle.
  - The engine never drops mem_req_valid before mem_req_ready.
- Minimum latency with zero-wait memory:
  - miss accepted at cycle 0;
  - request handshake at cycle 1;
  - beats at cycles 2–9;
  - WRITE at cycle 10;
  - refill_done at cycle 11;
  - next miss accepted at cycle 12.
- Reset mid-operation returns to IDLE with no array write. The memory side is reset by the same rst, so no stale beats arrive afterwards.
- Outputs that have no meaning outside their state are driven to 0.

Decomposition:
- Shared package holds:
  - constants TAG_W, IDX_W, OFF_W, WORD_W, BEATS, LINE_W=256;
  - the refill state enumeration;
  - address field slice helpers (tag/index/word-select bit ranges).
- One sub-module: refill_line_buffer. It holds the 3-bit beat counter, the 8x32 assembly register, beat write enable, the full flag at cnt==7, and the critical-word mux.
- The FSM and handshake logic stay in cache_refill_engine.

Test Plan:
- Basic refill: miss_addr=0x1234_56E8, zero-wait memory, beats 0xA0..0xA7 with last on beat 7 -> mem_req_addr=0x1234_56E0.
  - Check: tag_wen at cycle 10 with tag_waddr=7, tag_wdata=0x123456, data_wdata word k=0xA0+k.
  - Check: refill_done at cycle 11 with refill_word=0xA2, refill_err=0.
- Request backpressure: mem_req_ready low for 5 cycles -> mem_req_valid and mem_req_addr stay stable for all 5 cycles; exactly one request handshake; done at cycle 16.
- Response gaps: mem_rsp_valid toggled 1,0,1,0... -> beats are stored in order; no beat is lost or duplicated; data_wdata matches; array write occurs exactly once.
- Framing error: last asserted on beat 3 and deasserted on beat 7 -> all 8 beats are consumed; array write still occurs; refill_err=1 with refill_done.
- Reset mid-RECV: rst pulled low after 4 beats -> outputs return to reset values immediately; no tag_wen/data_wen; a fresh miss afterwards completes normally.
- Back-to-back misses: miss_valid held high with two addresses -> the second is accepted exactly one cycle after the first refill_done; miss_ready is 0 throughout the first refill.
